wb_arbiter: RTL



---
 rtl/wb_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave port between N masters.
// Ownership is held for a whole Wishbone cycle, so bursts are never interleaved.
// A watchdog answers a stalled strobe with a one-cycle error to the owner.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | no owner; arbitrate among m_cyc_i starting after r_last
//   ST_BUSY | r_grant owns the slave port until its m_cyc_i drops
module wb_arbiter #(
   parameter int N_MASTERS      = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      clk,
   input  logic                      rst_i,
   input  logic [N_MASTERS-1:0]      m_cyc_i,
   input  logic [N_MASTERS-1:0]      m_stb_i,
   input  logic [N_MASTERS-1:0]      m_we_i,
   input  logic [4*N_MASTERS-1:0]    m_sel_i,
   input  logic [32*N_MASTERS-1:0]   m_adr_i,
   input  logic [32*N_MASTERS-1:0]   m_dat_i,
   output logic [31:0]               m_dat_o,
   output logic [N_MASTERS-1:0]      m_ack_o,
   output logic [N_MASTERS-1:0]      m_err_o,
   output logic                      s_cyc_o,
   output logic                      s_stb_o,
   output logic                      s_we_o,
   output logic [3:0]                s_sel_o,
   output logic [31:0]               s_adr_o,
   output logic [31:0]               s_dat_o,
   input  logic [31:0]               s_dat_i,
   input  logic                      s_ack_i,
   input  logic                      s_err_i,
   output logic [N_MASTERS-1:0]      grant_o
);

   localparam int LW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [LW-1:0] LAST_RST = LW'(N_MASTERS - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t                r_state, w_state_nxt;
   logic [N_MASTERS-1:0]  r_grant, w_grant_nxt;
   logic [LW-1:0]         r_last, w_last_nxt;
   logic [CW-1:0]         r_wdog_cnt, w_wdog_cnt_nxt;

   logic                  w_busy;
   logic                  w_own_cyc;
   logic                  w_own_stb;
   logic                  w_own_we;
   logic [3:0]            w_sel;
   logic [31:0]           w_adr;
   logic [31:0]           w_dat;
   logic                  w_wdog_err;

   logic                  w_req_any;
   logic                  w_hi_found;
   logic [LW-1:0]         w_hi_idx;
   logic [LW-1:0]         w_lo_idx;
   logic [LW-1:0]         w_pick;
   logic [N_MASTERS-1:0]  w_pick_onehot;

   assign w_busy = (r_state == ST_BUSY);

   // Round-robin pick: lowest requester above r_last, else lowest requester overall
   always_comb begin
      w_req_any     = 1'b0;
      w_hi_found    = 1'b0;
      w_hi_idx      = '0;
      w_lo_idx      = '0;
      w_pick_onehot = '0;
      for (int k = N_MASTERS - 1; k >= 0; k--) begin
         if (m_cyc_i[k]) begin
            w_req_any = 1'b1;
            w_lo_idx  = LW'(k);
            if (k > int'(r_last)) begin
               w_hi_found = 1'b1;
               w_hi_idx   = LW'(k);
            end
         end
      end
      w_pick = w_hi_found ? w_hi_idx : w_lo_idx;
      for (int k = 0; k < N_MASTERS; k++) begin
         w_pick_onehot[k] = (LW'(k) == w_pick);
      end
   end

   // One-hot mux of the owner's request onto the slave side
   always_comb begin
      w_sel = '0;
      w_adr = '0;
      w_dat = '0;
      for (int k = 0; k < N_MASTERS; k++) begin
         if (r_grant[k]) begin
            w_sel = w_sel | m_sel_i[4*k +: 4];
            w_adr = w_adr | m_adr_i[32*k +: 32];
            w_dat = w_dat | m_dat_i[32*k +: 32];
         end
      end
   end

   assign w_own_cyc = |(m_cyc_i & r_grant);
   assign w_own_stb = |(m_stb_i & m_cyc_i & r_grant);
   assign w_own_we  = |(m_we_i & r_grant);

   // Slave-side outputs are live only while an owner exists
   always_comb begin
      s_cyc_o = w_busy & w_own_cyc;
      s_stb_o = w_busy & w_own_stb;
      s_we_o  = w_busy & w_own_cyc & w_own_we;
      s_sel_o = w_busy ? w_sel : 4'h0;
      s_adr_o = w_busy ? w_adr : 32'h0;
      s_dat_o = w_busy ? w_dat : 32'h0;
      m_dat_o = w_busy ? s_dat_i : 32'h0;
      m_ack_o = w_busy ? (r_grant & {N_MASTERS{s_ack_i}}) : '0;
      m_err_o = w_busy ? (r_grant & {N_MASTERS{s_err_i | w_wdog_err}}) : '0;
      grant_o = r_grant;
   end

   // Watchdog: count stalled strobe cycles, fire and restart at the limit
   always_comb begin
      w_wdog_err     = 1'b0;
      w_wdog_cnt_nxt = '0;
      if (TIMEOUT_CYCLES > 0) begin
         w_wdog_err = w_busy && (r_wdog_cnt == CNT_MAX);
         if (w_busy && w_own_cyc && s_stb_o && !s_ack_i && !s_err_i && !w_wdog_err) begin
            w_wdog_cnt_nxt = r_wdog_cnt + CW'(1);
         end
      end
   end

   // Next-state: arbitrate in IDLE, hold ownership until the owner drops cyc
   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_last_nxt  = r_last;
      case (r_state)
         ST_IDLE: begin
            if (w_req_any) begin
               w_state_nxt = ST_BUSY;
               w_grant_nxt = w_pick_onehot;
               w_last_nxt  = w_pick;
            end
         end
         ST_BUSY: begin
            if (!w_own_cyc) begin
               w_state_nxt = ST_IDLE;
               w_grant_nxt = '0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
         end
      endcase
   end

   // State registers with synchronous reset; last=N-1 gives master 0 first win
   always_ff @(posedge clk) begin
      if (rst_i) begin
         r_state    <= ST_IDLE;
         r_grant    <= '0;
         r_last     <= LAST_RST;
         r_wdog_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_grant    <= w_grant_nxt;
         r_last     <= w_last_nxt;
         r_wdog_cnt <= w_wdog_cnt_nxt;
      end
   end

endmodule
